// File: rtl/counter_run_controller_pkg.sv
// counter_run_controller_pkg: mode codes and FSM state encodings shared by the counter controller
package counter_run_controller_pkg;
  typedef enum logic [1:0] {MODE_UP = 2'd0, MODE_DOWN = 2'd1, MODE_REVERSE = 2'd2, MODE_HOLD = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/counter_run_controller_if.sv
// counter_run_controller_if: command handshake and counter status bundle
interface counter_run_controller_if #(
  parameter int MAX = 16,
  parameter int LEN_W = 8
);
  localparam int DIGITS = $clog2(MAX);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [DIGITS-1:0] cmd_start;
  logic [LEN_W-1:0]  cmd_len;
  logic              abort;
  logic [DIGITS-1:0] count;
  logic              dir;
  logic              busy;
  logic              done;
  logic              wrap;
  modport master (
    output cmd_valid, cmd_mode, cmd_start, cmd_len, abort,
    input  cmd_ready, count, dir, busy, done, wrap
  );
  modport slave (
    input  cmd_valid, cmd_mode, cmd_start, cmd_len, abort,
    output cmd_ready, count, dir, busy, done, wrap
  );
endinterface

// File: rtl/counter_run_controller_step.sv
// counter_run_controller_step: combinational next count/direction and endpoint detect for one step
module counter_run_controller_step
  import counter_run_controller_pkg::*;
#(
  parameter int MAX = 16,
  localparam int DIGITS = $clog2(MAX)
) (
  input  logic [DIGITS-1:0] count_i,
  input  logic              dir_i,
  input  mode_e             mode_i,
  output logic [DIGITS-1:0] next_count_o,
  output logic              next_dir_o,
  output logic              endpoint_o
);
  logic top, bot, up;
  assign top = count_i == DIGITS'(MAX - 1);
  assign bot = count_i == '0;
  // ping-pong keeps climbing unless at the top, and turns upward only at zero
  assign up = dir_i ? !top : bot;
  always_comb begin
    next_count_o = mode_i == MODE_UP      ? (top ? '0 : count_i + 1'b1) :
                   mode_i == MODE_DOWN    ? (bot ? DIGITS'(MAX - 1) : count_i - 1'b1) :
                   mode_i == MODE_REVERSE ? (up ? count_i + 1'b1 : count_i - 1'b1) : count_i;
    next_dir_o   = mode_i == MODE_REVERSE ? up : dir_i;
    endpoint_o   = mode_i == MODE_UP   ? top :
                   mode_i == MODE_DOWN ? bot :
                   (mode_i == MODE_REVERSE) && (dir_i ? top : bot);
  end
endmodule

// File: rtl/counter_run_controller.sv
// counter_run_controller: accepts run commands and steps a modulo-MAX counter once per clock
module counter_run_controller
  import counter_run_controller_pkg::*;
#(
  parameter int MAX = 16,
  parameter int LEN_W = 8
) (
  input logic clock,
  input logic reset_n,
  counter_run_controller_if.slave bus
);
  localparam int DIGITS = $clog2(MAX);
  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [DIGITS-1:0] count_q, count_d, next_count, start_c;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              dir_q, dir_d, wrap_q, wrap_d, next_dir, endpoint;
  // a power-of-two modulus cannot receive an out-of-range start value
  if (MAX == (1 << DIGITS)) begin : g_pow2
    assign start_c = bus.cmd_start;
  end else begin : g_clamp
    assign start_c = bus.cmd_start > DIGITS'(MAX - 1) ? DIGITS'(MAX - 1) : bus.cmd_start;
  end
  counter_run_controller_step #(.MAX(MAX)) u_step (
    .count_i(count_q),
    .dir_i(dir_q),
    .mode_i(mode_q),
    .next_count_o(next_count),
    .next_dir_o(next_dir),
    .endpoint_o(endpoint)
  );
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    if (state_q == IDLE && bus.cmd_valid) begin
      count_d = start_c;
      mode_d  = mode_e'(bus.cmd_mode);
      dir_d   = bus.cmd_mode != MODE_DOWN;
      rem_d   = bus.cmd_len;
      state_d = bus.cmd_len != '0 ? RUN : DONE;
    end else if (state_q == RUN) begin
      state_d = bus.abort ? IDLE : rem_q == LEN_W'(1) ? DONE : RUN;
      count_d = bus.abort ? count_q : next_count;
      dir_d   = bus.abort ? dir_q : next_dir;
      rem_d   = bus.abort ? rem_q : rem_q - 1'b1;
      wrap_d  = !bus.abort && endpoint;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_UP;
      count_q <= '0;
      dir_q   <= 1'b1;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
    end
  end
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.busy      = state_q == RUN;
  assign bus.done      = state_q == DONE;
  assign bus.count     = count_q;
  assign bus.dir       = dir_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_counter_run_controller.sv
// tb_counter_run_controller: drives a MAX=16 and a MAX=10 controller in lockstep against a rule-level model
module tb_counter_run_controller;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] cmd_mode = '0;
  logic [3:0] cmd_start = '0;
  logic [7:0] cmd_len = '0;
  int         errors = 0;
  int         checks = 0;
  int         maxv[2] = '{16, 10};
  logic [3:0] cnt[2];
  logic       dir_o[2];
  logic       wrap_o[2];
  logic [2:0] st_v[2];
  localparam logic [2:0] S_IDLE = 3'b100, S_RUN = 3'b010, S_DONE = 3'b001;

  always #5 clock = ~clock;

  counter_run_controller_if #(.MAX(16), .LEN_W(8)) if16 ();
  counter_run_controller_if #(.MAX(10), .LEN_W(8)) if10 ();

  counter_run_controller #(.MAX(16), .LEN_W(8)) dut16 (.clock(clock), .reset_n(reset_n), .bus(if16.slave));
  counter_run_controller #(.MAX(10), .LEN_W(8)) dut10 (.clock(clock), .reset_n(reset_n), .bus(if10.slave));

  assign if16.cmd_valid = cmd_valid;
  assign if16.abort     = abort;
  assign if16.cmd_mode  = cmd_mode;
  assign if16.cmd_start = cmd_start;
  assign if16.cmd_len   = cmd_len;
  assign if10.cmd_valid = cmd_valid;
  assign if10.abort     = abort;
  assign if10.cmd_mode  = cmd_mode;
  assign if10.cmd_start = cmd_start;
  assign if10.cmd_len   = cmd_len;
  assign cnt[0]    = if16.count;
  assign cnt[1]    = if10.count;
  assign dir_o[0]  = if16.dir;
  assign dir_o[1]  = if10.dir;
  assign wrap_o[0] = if16.wrap;
  assign wrap_o[1] = if10.wrap;
  assign st_v[0]   = {if16.cmd_ready, if16.busy, if16.done};
  assign st_v[1]   = {if10.cmd_ready, if10.busy, if10.done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input int j, input int c, input bit d, input bit w, input logic [2:0] st);
    chk($sformatf("%s.count.m%0d", tag, maxv[j]), 32'(cnt[j]), 32'(c));
    chk($sformatf("%s.dir.m%0d", tag, maxv[j]), 32'(dir_o[j]), 32'(d));
    chk($sformatf("%s.wrap.m%0d", tag, maxv[j]), 32'(wrap_o[j]), 32'(w));
    chk($sformatf("%s.status.m%0d", tag, maxv[j]), 32'(st_v[j]), 32'(st));
  endtask

  function automatic void model_step(input int mx, input int mode, inout int c, inout bit d, output bit w);
    w = 1'b0;
    case (mode)
      0: begin w = c == mx - 1; c = (c + 1) % mx; end
      1: begin w = c == 0; c = (c + mx - 1) % mx; end
      2: begin
        if (d ? c == mx - 1 : c == 0) begin d = !d; w = 1'b1; end
        c = d ? c + 1 : c - 1;
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // entered and left right after a falling edge
  task automatic run_cmd(input string tag, input int mode, input int start, input int len, input int abort_at);
    int c[2];
    bit d[2];
    bit w[2];
    cmd_valid = 1'b1;
    cmd_mode  = 2'(mode);
    cmd_start = 4'(start);
    cmd_len   = 8'(len);
    for (int j = 0; j < 2; j++) begin
      c[j] = start > maxv[j] - 1 ? maxv[j] - 1 : start;
      d[j] = mode != 1;
      w[j] = 1'b0;
    end
    tick();
    cmd_valid = 1'b0;
    for (int j = 0; j < 2; j++) exp_out({tag, ".acc"}, j, c[j], d[j], 1'b0, len == 0 ? S_DONE : S_RUN);
    for (int i = 1; i <= len; i++) begin
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int j = 0; j < 2; j++) exp_out({tag, ".abort"}, j, c[j], d[j], 1'b0, S_IDLE);
        return;
      end
      for (int j = 0; j < 2; j++) model_step(maxv[j], mode, c[j], d[j], w[j]);
      tick();
      for (int j = 0; j < 2; j++) exp_out($sformatf("%s.s%0d", tag, i), j, c[j], d[j], w[j], i == len ? S_DONE : S_RUN);
    end
    tick();
    for (int j = 0; j < 2; j++) exp_out({tag, ".end"}, j, c[j], d[j], 1'b0, S_IDLE);
  endtask

  initial begin
    int m, s, l, a;
    #12;
    for (int j = 0; j < 2; j++) exp_out("reset", j, 0, 1'b1, 1'b0, S_IDLE);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    for (int j = 0; j < 2; j++) exp_out("idle", j, 0, 1'b1, 1'b0, S_IDLE);
    run_cmd("t1_up", 0, 14, 4, 0);
    run_cmd("t2_down", 1, 1, 3, 0);
    run_cmd("t3_rev", 2, 13, 5, 0);
    run_cmd("t3_rev_top", 2, 15, 3, 0);
    run_cmd("t4_load", 0, 9, 0, 0);
    run_cmd("t4_clamp", 0, 15, 0, 0);
    run_cmd("t4_clamp_up", 0, 12, 3, 0);
    run_cmd("hold", 3, 6, 4, 0);
    run_cmd("t5_abort", 0, 3, 10, 3);
    // valid held through DONE, with abort asserted where it must be ignored
    cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_start = 4'd5; cmd_len = 8'd0; abort = 1'b1;
    tick();
    for (int j = 0; j < 2; j++) exp_out("t5_hold.done", j, 5, 1'b1, 1'b0, S_DONE);
    cmd_start = 4'd7;
    tick();
    for (int j = 0; j < 2; j++) exp_out("t5_hold.idle", j, 5, 1'b1, 1'b0, S_IDLE);
    tick();
    for (int j = 0; j < 2; j++) exp_out("t5_hold.acc", j, 7, 1'b1, 1'b0, S_DONE);
    cmd_valid = 1'b0; abort = 1'b0;
    tick();
    for (int j = 0; j < 2; j++) exp_out("t5_hold.end", j, 7, 1'b1, 1'b0, S_IDLE);
    // asynchronous reset between edges while counting down
    cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_start = 4'd5; cmd_len = 8'd10;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int j = 0; j < 2; j++) exp_out("t6_pre", j, 4, 1'b0, 1'b0, S_RUN);
    #2 reset_n = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) exp_out("t6_rst", j, 0, 1'b1, 1'b0, S_IDLE);
    @(negedge clock);
    reset_n = 1'b1;
    run_cmd("t6_after", 2, 1, 4, 0);
    for (int n = 0; n < 30; n++) begin
      m = int'($urandom_range(0, 3));
      s = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 20));
      a = ($urandom_range(0, 3) == 0 && l > 0) ? int'($urandom_range(1, l)) : 0;
      run_cmd($sformatf("rnd%0d", n), m, s, l, a);
      if ($urandom_range(0, 1) == 1) tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
